fetch_stage: RTL and testbench

Instruction fetch stage of the RISC-V pipeline. Drives PC sequencing and the instruction-memory request/response handshake. Buffers returned instructions in a 2-entry queue and presents them to decode together with the fetch exception flags `f_iam`, `f_iaf` and `f_ii`. Accepts a redirect from execute/commit and discards stale in-flight responses after it.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_queue.sv | 77 +++++++
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: queue entry layout, FSM states,
// the NOP used for faulting entries and the illegal-encoding check.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [0:0] {
        StRun,
        StHalt
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
        logic                  iam;
        logic                  iaf;
        logic                  ii;
    } fetch_entry_t;

    // Anything that is not a 32-bit encoding, plus the all-zero and all-one words.
    function automatic logic is_illegal(input logic [31:0] data);
        return (data[1:0] != 2'b11) || (data == 32'h0000_0000) || (data == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry registered FIFO between fetch and decode; entry 0 is always the head.
// Supports flush and a simultaneous push/pop, including on a full queue.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         valid_o,
    output logic         full_o,
    output logic [1:0]   count_o
);

    fetch_entry_t e0_q, e0_d;
    fetch_entry_t e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_pop;
    logic         do_push;

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        do_pop  = pop_i && (cnt_q != 2'd0);
        do_push = push_i && ((cnt_q != 2'd2) || do_pop);
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_d = entry_i;
                    end else begin
                        e1_d = entry_i;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_d = entry_i;
                    end else begin
                        e0_d = e1_q;
                        e1_d = entry_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = e0_q;
    assign valid_o = (cnt_q != 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// RISC-V instruction fetch: PC sequencing, imem handshake, stale-response dropping, fault flags.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            imem_rsp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            d_ready,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall,
`endif
    output logic            f_valid,
    output logic [XLEN-1:0] f_pc,
    output logic [31:0]     f_instr,
    output logic            f_iam,
    output logic            f_iaf,
    output logic            f_ii
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [1:0]      out_q, out_d;
    logic [1:0]      drop_q, drop_d;

    fetch_entry_t    q_head;
    fetch_entry_t    push_entry;
    logic            q_valid;
    logic            q_full;
    logic [1:0]      q_count;
    logic            pop;
    logic            push;
    logic            fire;
    logic [2:0]      credit;
    logic            misalign_push;
    logic            rsp_push;
    logic [XLEN-1:0] rsp_pc;

    assign pop = q_valid && d_ready;

    // Counting this cycle's pop as free space keeps one request per cycle with 1-cycle memory.
    assign credit = {1'b0, out_q} + {1'b0, q_count} - {2'b00, pop};

    assign imem_req_valid = RESET && (state_q == StRun) && (pc_q[1:0] == 2'b00) &&
                            !redirect_valid && (credit < 3'd2);
    assign imem_req_addr  = pc_q;
    assign fire           = imem_req_valid && imem_req_ready;

    // Non-dropped in-flight requests are the newest ones, issued back to back ending at pc_q.
    assign rsp_pc = pc_q - {{(XLEN-4){1'b0}}, out_q, 2'b00};

    assign rsp_push      = imem_rsp_valid && (drop_q == 2'd0) && !redirect_valid;
    assign misalign_push = (state_q == StRun) && (pc_q[1:0] != 2'b00) && (out_q == 2'd0) &&
                           (drop_q == 2'd0) && !q_full && !redirect_valid;

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (rsp_push) begin
            push             = 1'b1;
            push_entry.pc    = rsp_pc;
            push_entry.instr = imem_rsp_err ? NOP_INSTR : imem_rsp_data;
            push_entry.iaf   = imem_rsp_err;
            push_entry.ii    = !imem_rsp_err && is_illegal(imem_rsp_data);
        end else if (misalign_push) begin
            push             = 1'b1;
            push_entry.pc    = pc_q;
            push_entry.instr = NOP_INSTR;
            push_entry.iam   = 1'b1;
        end
    end

    always_comb begin
        out_d   = out_q + {1'b0, fire} - {1'b0, imem_rsp_valid};
        pc_d    = fire ? (pc_q + 'd4) : pc_q;
        state_d = state_q;
        drop_d  = drop_q;
        if (imem_rsp_valid && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
        end
        if (push && (push_entry.iam || push_entry.iaf || push_entry.ii)) begin
            state_d = StHalt;
            drop_d  = out_d;
        end
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = StRun;
            drop_d  = out_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            out_q   <= 2'd0;
            drop_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    fetch_queue u_queue (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .flush_i (redirect_valid),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (q_head),
        .valid_o (q_valid),
        .full_o  (q_full),
        .count_o (q_count)
    );

    assign f_valid = q_valid;
    assign f_pc    = q_head.pc;
    assign f_instr = q_head.instr;
    assign f_iam   = q_head.iam;
    assign f_iaf   = q_head.iaf;
    assign f_ii    = q_head.ii;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            perf_fetched_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_q + {31'd0, pop};
            perf_stall_q   <= perf_stall_q + {31'd0, (q_valid && !d_ready)};
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory model with settable latency,
// hand-computed checks on reset, throughput, backpressure, redirect and fault flags.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        d_ready;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_iam;
    logic        f_iaf;
    logic        f_ii;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] addr_q[$];
    int          due_q[$];
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] zero_addr = 32'hFFFF_FFFF;
    bit          track = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    int          pop_cnt = 0;
    bit          found;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .d_ready        (d_ready),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
`endif
        .f_valid        (f_valid),
        .f_pc           (f_pc),
        .f_instr        (f_instr),
        .f_iam          (f_iam),
        .f_iaf          (f_iaf),
        .f_ii           (f_ii)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [31:0] a);
        return {a[19:0], 12'h013};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start of a new cycle: clear one-shot inputs and present any due memory response.
    task automatic next_cycle();
        logic [31:0] a;
        int          d;
        @(posedge CLK);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        if (addr_q.size() > 0 && due_q[0] <= cyc) begin
            a = addr_q.pop_front();
            d = due_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = (a == zero_addr) ? 32'h0 : mk(a);
            imem_rsp_err   = (a == err_addr);
        end
    endtask

    // Mid-cycle: record accepted requests and check in-order delivery to decode.
    task automatic sample();
        @(negedge CLK);
        if (imem_req_valid && imem_req_ready) begin
            addr_q.push_back(imem_req_addr);
            due_q.push_back(cyc + lat);
        end
        if (track && f_valid && d_ready) begin
            chk("inorder_pc", f_pc, exp_pc);
            chk("inorder_instr", f_instr, mk(exp_pc));
            chk("inorder_flags", {29'b0, f_iam, f_iaf, f_ii}, 32'h0);
            exp_pc  = exp_pc + 32'd4;
            pop_cnt++;
        end
    endtask

    task automatic tick();
        next_cycle();
        sample();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        RESET          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        d_ready        = 1'b1;

        // Reset held
        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_f_valid", 32'(f_valid), 32'd0);
        chk("rst_f_pc", f_pc, 32'h0);
        chk("rst_f_instr", f_instr, 32'h0);
        chk("rst_f_flags", {29'b0, f_iam, f_iaf, f_ii}, 32'h0);

        // Reset release, 1-cycle memory, full throughput
        next_cycle();
        RESET  = 1'b1;
        track  = 1'b1;
        exp_pc = 32'h100;
        sample();
        chk("req0_valid", 32'(imem_req_valid), 32'd1);
        chk("req0_addr", imem_req_addr, 32'h100);
        chk("req0_f_valid", 32'(f_valid), 32'd0);
        tick();
        chk("req1_addr", imem_req_addr, 32'h104);
        chk("req1_f_valid", 32'(f_valid), 32'd0);
        tick();
        chk("req2_addr", imem_req_addr, 32'h108);
        chk("first_f_valid", 32'(f_valid), 32'd1);
        tick();
        chk("req3_addr", imem_req_addr, 32'h10c);
        chk("throughput_pops", 32'(pop_cnt), 32'd2);

        // Decode backpressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            d_ready = 1'b0;
            sample();
        end
        chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        chk("stall_f_valid", 32'(f_valid), 32'd1);
        chk("stall_head_pc", f_pc, 32'h108);
        chk("stall_inflight", 32'(addr_q.size()), 32'd0);
        next_cycle();
        d_ready = 1'b1;
        sample();
        chk("resume_req_addr", imem_req_addr, 32'h110);
        run(6);

        // Redirect with two requests outstanding (3-cycle memory)
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (addr_q.size() == 2) found = 1'b1;
        end
        chk("two_outstanding", 32'(found), 32'd1);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        track          = 1'b0;
        sample();
        chk("redir_no_req", 32'(imem_req_valid), 32'd0);
        exp_pc  = 32'h2000;
        track   = 1'b1;
        pop_cnt = 0;
        tick();
        chk("redir_f_valid", 32'(f_valid), 32'd0);
        for (int i = 0; i < 20 && pop_cnt == 0; i++) tick();
        chk("redir_first_pop", 32'(pop_cnt), 32'd1);
        run(6);

        // Redirect to a misaligned PC
        lat = 1;
        run(8);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2002;
        track          = 1'b0;
        sample();
        chk("mis_redir_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        chk("mis_no_req", 32'(imem_req_valid), 32'd0);
        chk("mis_f_valid0", 32'(f_valid), 32'd0);
        tick();
        chk("mis_f_valid", 32'(f_valid), 32'd1);
        chk("mis_f_pc", f_pc, 32'h2002);
        chk("mis_f_instr", f_instr, 32'h0000_0013);
        chk("mis_flags", {29'b0, f_iam, f_iaf, f_ii}, 32'h4);
        chk("mis_halt_req", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mis_halt_idle", {30'b0, imem_req_valid, f_valid}, 32'h0);
        end

        // Access fault on 0x104; the response for 0x108 must be discarded
        err_addr = 32'h104;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        sample();
        tick();
        chk("err_req0", imem_req_addr, 32'h100);
        chk("err_req0_valid", 32'(imem_req_valid), 32'd1);
        tick();
        chk("err_req1", imem_req_addr, 32'h104);
        tick();
        chk("err_req2", imem_req_addr, 32'h108);
        chk("err_head0_pc", f_pc, 32'h100);
        chk("err_head0_flags", {29'b0, f_iam, f_iaf, f_ii}, 32'h0);
        tick();
        chk("err_f_valid", 32'(f_valid), 32'd1);
        chk("err_f_pc", f_pc, 32'h104);
        chk("err_f_instr", f_instr, 32'h0000_0013);
        chk("err_flags", {29'b0, f_iam, f_iaf, f_ii}, 32'h2);
        chk("err_halt_req", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_drop_idle", {30'b0, imem_req_valid, f_valid}, 32'h0);
        end

        // All-zero instruction word is illegal, not a fault
        err_addr  = 32'hFFFF_FFFF;
        zero_addr = 32'h200;
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        sample();
        tick();
        chk("ii_req0", imem_req_addr, 32'h200);
        tick();
        tick();
        chk("ii_f_valid", 32'(f_valid), 32'd1);
        chk("ii_f_pc", f_pc, 32'h200);
        chk("ii_f_instr", f_instr, 32'h0);
        chk("ii_flags", {29'b0, f_iam, f_iaf, f_ii}, 32'h1);
        chk("ii_halt_req", 32'(imem_req_valid), 32'd0);
        tick();
        chk("ii_after_f_valid", 32'(f_valid), 32'd0);

        // Redirect resumes normal fetch; request at the target in the next cycle
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        sample();
        tick();
        chk("res_f_valid", 32'(f_valid), 32'd0);
        chk("res_req_valid", 32'(imem_req_valid), 32'd1);
        chk("res_req_addr", imem_req_addr, 32'h300);
        exp_pc  = 32'h300;
        track   = 1'b1;
        pop_cnt = 0;
        run(8);
        chk("res_pops", 32'(pop_cnt), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
